// File: rtl/instruction_decode_queue_pkg.sv
// Shared opcode, MAC command and FSM state encodings for the instruction decode queue.
// Field widths live in the modules so DIM_W/ADDR_W stay overridable per instance.
package instruction_decode_queue_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'b0000,
    OP_MATMUL = 4'b0001,
    OP_LOADW  = 4'b0010,
    OP_HALT   = 4'b1111
  } opcode_e;

  typedef enum logic [2:0] {
    MAC_OP_NONE   = 3'b000,
    MAC_OP_LOADW  = 3'b001,
    MAC_OP_MATMUL = 3'b010
  } mac_op_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  function automatic logic is_cmd_op(input logic [3:0] op);
    return (op == OP_MATMUL) || (op == OP_LOADW);
  endfunction

  function automatic logic [2:0] mac_code(input logic [3:0] op);
    logic [2:0] code;
    code = MAC_OP_NONE;
    if (op == OP_MATMUL) code = MAC_OP_MATMUL;
    else if (op == OP_LOADW) code = MAC_OP_LOADW;
    return code;
  endfunction

endpackage

// File: rtl/instruction_decode_queue_instr_fifo.sv
// Circular instruction buffer with occupancy count and synchronous flush.
// Pushes are refused when full; pops from an empty queue are ignored.
module instruction_decode_queue_instr_fifo #(
  parameter  int WIDTH = 49,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_o == CNT_W'(DEPTH));
  assign empty_o = (count_o == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/instruction_decode_queue.sv
// Buffers host instructions, decodes the queue head and issues one registered
// MAC/unified-buffer command per valid/ready handshake, with HALT/resume and flush.
module instruction_decode_queue
  import instruction_decode_queue_pkg::*;
#(
  parameter  int DIM_W   = 7,
  parameter  int ADDR_W  = 12,
  parameter  int DEPTH   = 4,
  localparam int INSTR_W = 4 + 3*DIM_W + 2*ADDR_W,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  logic               flush_i,
  input  logic               resume_i,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  output logic [2:0]         MAC_op_o,
  output logic [DIM_W-1:0]   V_dim_o,
  output logic [DIM_W-1:0]   U_dim_o,
  output logic [DIM_W-1:0]   ITER_dim_o,
  output logic [DIM_W-1:0]   V_dim1_o,
  output logic [DIM_W-1:0]   U_dim1_o,
  output logic [DIM_W-1:0]   ITER_dim1_o,
  output logic [ADDR_W-1:0]  unified_buffer_addr_start_rd_o,
  output logic [ADDR_W-1:0]  unified_buffer_addr_start_wr_o,
  output logic               halted_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   count_o
);

  typedef struct packed {
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DIM_W-1:0]  iter;
    logic [DIM_W-1:0]  u;
    logic [DIM_W-1:0]  v;
    logic [3:0]        op;
  } instr_t;

  state_e             state;
  state_e             state_next;
  logic [INSTR_W-1:0] head_raw;
  instr_t             head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               dims_ok;
  logic               load_cmd;
  logic               drop_illegal;

  assign head          = instr_t'(head_raw);
  assign instr_ready_o = !fifo_full;
  assign halted_o      = (state == ST_HALTED);

  // Head may only leave when the output register is free or being emptied this cycle
  assign pop = (state == ST_RUN) && !fifo_empty && (!cmd_valid_o || cmd_ready_i) && !flush_i;

  assign dims_ok      = (head.v != '0) && (head.u != '0) && (head.iter != '0);
  assign load_cmd     = pop && is_cmd_op(head.op) && dims_ok;
  assign drop_illegal = pop && !load_cmd && (head.op != OP_NOP) && (head.op != OP_HALT);

  instruction_decode_queue_instr_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (instr_valid_i),
    .data_i  (instr_i),
    .pop_i   (pop),
    .data_o  (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_RUN:    if (pop && (head.op == OP_HALT)) state_next = ST_HALTED;
        ST_HALTED: if (resume_i) state_next = ST_RUN;
        default:   state_next = ST_RUN;
      endcase
    end
  end

  // Fields only change on a load, so they stay stable while the controller stalls
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cmd_valid_o                    <= 1'b0;
      MAC_op_o                       <= MAC_OP_NONE;
      V_dim_o                        <= '0;
      U_dim_o                        <= '0;
      ITER_dim_o                     <= '0;
      V_dim1_o                       <= '0;
      U_dim1_o                       <= '0;
      ITER_dim1_o                    <= '0;
      unified_buffer_addr_start_rd_o <= '0;
      unified_buffer_addr_start_wr_o <= '0;
      illegal_o                      <= 1'b0;
    end else if (flush_i) begin
      cmd_valid_o <= 1'b0;
      illegal_o   <= 1'b0;
    end else begin
      if (load_cmd) begin
        cmd_valid_o                    <= 1'b1;
        MAC_op_o                       <= mac_code(head.op);
        V_dim_o                        <= head.v;
        U_dim_o                        <= head.u;
        ITER_dim_o                     <= head.iter;
        V_dim1_o                       <= head.v - 1'b1;
        U_dim1_o                       <= head.u - 1'b1;
        ITER_dim1_o                    <= head.iter - 1'b1;
        unified_buffer_addr_start_rd_o <= head.rd_addr;
        unified_buffer_addr_start_wr_o <= head.wr_addr;
      end else if (cmd_ready_i) begin
        cmd_valid_o <= 1'b0;
      end
      if (drop_illegal) illegal_o <= 1'b1;
    end
  end

endmodule
